// File: rtl/data_ram_ctrl_pkg.sv
// Shared defines for the data RAM controller: widths, default geometry and
// the address window check used by the controller.
package data_ram_ctrl_pkg;

  localparam int unsigned DATA_WIDTH      = 32;
  localparam int unsigned RV32_ADDR_WIDTH = 32;
  localparam int unsigned DRAM_DEPTH      = 4096;
  localparam logic [RV32_ADDR_WIDTH-1:0] DRAM_BASE_ADDR = 32'h0000_0000;
  localparam int unsigned DRAM_IDX_WIDTH  = $clog2(DRAM_DEPTH);

  // Unsigned window test; span is 33 bits so base + span never wraps.
  function automatic logic addr_in_window(
    input logic [RV32_ADDR_WIDTH-1:0] addr,
    input logic [RV32_ADDR_WIDTH-1:0] base,
    input logic [RV32_ADDR_WIDTH:0]   span
  );
    logic [RV32_ADDR_WIDTH-1:0] offset;
    offset = addr - base;
    return (addr >= base) && ({1'b0, offset} < span);
  endfunction

endpackage

// File: rtl/data_ram_ctrl_byte_bank.sv
// One byte lane of the data RAM: DEPTH x 8, single write enable,
// registered (synchronous) read port, read-first on same-index access.
module dram_byte_bank
  import data_ram_ctrl_pkg::*;
#(
  parameter  int unsigned DEPTH = DRAM_DEPTH,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [7:0]       wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_data
);

  logic [7:0] mem [DEPTH];

  // NOTE: storage and its read register carry no reset so the array maps onto
  // block RAM; a reset here would force a flop-based implementation.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= wr_data;
    end
    rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/data_ram_ctrl.sv
// Data RAM controller: four byte banks, range check, sticky error capture.
// Define DRAM_FWD_EN for write-first collisions; default build is read-first.
module data_ram_ctrl
  import data_ram_ctrl_pkg::*;
#(
  parameter int unsigned                 DEPTH     = DRAM_DEPTH,
  parameter logic [RV32_ADDR_WIDTH-1:0]  BASE_ADDR = DRAM_BASE_ADDR
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [RV32_ADDR_WIDTH-1:0] ram_rd_addr_i,
  input  logic [RV32_ADDR_WIDTH-1:0] ram_wr_addr_i,
  input  logic [DATA_WIDTH-1:0]      ram_wr_data_i,
  input  logic [3:0]                 ram_wr_en_i,
  output logic [DATA_WIDTH-1:0]      ram_rd_data_o,
  output logic                       err_o,
  output logic [RV32_ADDR_WIDTH-1:0] err_addr_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [RV32_ADDR_WIDTH:0] SPAN = (RV32_ADDR_WIDTH+1)'(DEPTH) << 2;

  logic [RV32_ADDR_WIDTH-1:0] rd_off, wr_off;
  logic [IDX_W-1:0]           rd_idx, wr_idx;
  logic                       rd_ok, wr_ok, rd_bad, wr_bad;
  logic [3:0]                 lane_we;
  logic [DATA_WIDTH-1:0]      bank_q, rd_word;
  logic                       rd_ok_q, err_q;
  logic [RV32_ADDR_WIDTH-1:0] err_addr_q;

  assign rd_off = ram_rd_addr_i - BASE_ADDR;
  assign wr_off = ram_wr_addr_i - BASE_ADDR;
  assign rd_idx = rd_off[IDX_W+1:2];
  assign wr_idx = wr_off[IDX_W+1:2];
  assign rd_ok  = addr_in_window(ram_rd_addr_i, BASE_ADDR, SPAN);
  assign wr_ok  = addr_in_window(ram_wr_addr_i, BASE_ADDR, SPAN);
  assign rd_bad = !rd_ok;
  assign wr_bad = (ram_wr_en_i != 4'b0000) && !wr_ok;

  // Gating with rst_n drops a write that is pending when reset asserts.
  assign lane_we = ram_wr_en_i & {4{wr_ok && rst_n}};

  for (genvar g = 0; g < 4; g++) begin : g_lane
    dram_byte_bank #(.DEPTH(DEPTH)) u_bank (
      .clk     (clk),
      .we      (lane_we[g]),
      .wr_idx  (wr_idx),
      .wr_data (ram_wr_data_i[8*g +: 8]),
      .rd_idx  (rd_idx),
      .rd_data (bank_q[8*g +: 8])
    );
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ok_q    <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      rd_ok_q <= rd_ok;
      if (!err_q && (rd_bad || wr_bad)) begin
        err_q      <= 1'b1;
        err_addr_q <= wr_bad ? ram_wr_addr_i : ram_rd_addr_i;
      end
    end
  end

`ifdef DRAM_FWD_EN
  logic [3:0]            fwd_lanes_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_lanes_q <= '0;
      fwd_data_q  <= '0;
    end else begin
      fwd_lanes_q <= (rd_ok && rd_idx == wr_idx) ? lane_we : 4'b0000;
      fwd_data_q  <= ram_wr_data_i;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    rd_word = bank_q;
    for (int i = 0; i < 4; i++) begin
      if (fwd_lanes_q[i]) begin
        rd_word[8*i +: 8] = fwd_data_q[8*i +: 8];
      end
    end
  end
`else
  assign rd_word = bank_q;
`endif

  // rd_ok_q is cleared asynchronously, which also forces zero during reset.
  assign ram_rd_data_o = rd_ok_q ? rd_word : '0;
  assign err_o         = err_q;
  assign err_addr_o    = err_addr_q;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Self-checking bench for data_ram_ctrl: randomized traffic in a small window
// against a word-array model, followed by directed boundary scenarios.
module tb_data_ram_ctrl;
  import data_ram_ctrl_pkg::*;

  localparam int unsigned DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] ram_rd_addr_i, ram_wr_addr_i, ram_wr_data_i;
  logic [3:0]  ram_wr_en_i;
  logic [31:0] ram_rd_data_o;
  logic        err_o;
  logic [31:0] err_addr_o;

  data_ram_ctrl #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ram_rd_addr_i (ram_rd_addr_i),
    .ram_wr_addr_i (ram_wr_addr_i),
    .ram_wr_data_i (ram_wr_data_i),
    .ram_wr_en_i   (ram_wr_en_i),
    .ram_rd_data_o (ram_rd_data_o),
    .err_o         (err_o),
    .err_addr_o    (err_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] model [DEPTH];
  bit          err_exp;
  logic [31:0] err_addr_exp;
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    longint ua, lo;
    ua = longint'({32'b0, a});
    lo = longint'({32'b0, BASE});
    return (ua >= lo) && (ua < lo + 4 * longint'(DEPTH));
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off / 4);
  endfunction

  function automatic logic [31:0] expect_rd(input logic [31:0] ra, wa, wd, input logic [3:0] we);
    logic [31:0] w;
    if (!in_rng(ra)) return 32'h0;
    w = model[widx(ra)];
`ifdef DRAM_FWD_EN
    if (we != 4'b0000 && in_rng(wa) && widx(wa) == widx(ra))
      for (int b = 0; b < 4; b++)
        if (we[b]) w[8*b +: 8] = wd[8*b +: 8];
`endif
    return w;
  endfunction

  // One clock of traffic; expected values are derived before the edge.
  task automatic do_cycle(input logic [31:0] ra, wa, wd, input logic [3:0] we, input bit chk_rd);
    logic [31:0] exp;
    bit bad_r, bad_w;
    exp   = expect_rd(ra, wa, wd, we);
    bad_r = !in_rng(ra);
    bad_w = (we != 4'b0000) && !in_rng(wa);
    ram_rd_addr_i = ra;
    ram_wr_addr_i = wa;
    ram_wr_data_i = wd;
    ram_wr_en_i   = we;
    @(posedge clk);
    #1;
    if (we != 4'b0000 && in_rng(wa))
      for (int b = 0; b < 4; b++)
        if (we[b]) model[widx(wa)][8*b +: 8] = wd[8*b +: 8];
    if (!err_exp && (bad_r || bad_w)) begin
      err_exp      = 1'b1;
      err_addr_exp = bad_w ? wa : ra;
    end
    last_rd = ram_rd_data_o;
    if (chk_rd) check("rd_data", ram_rd_data_o, exp);
    check("err", {31'b0, err_o}, {31'b0, err_exp});
    check("err_addr", err_addr_o, err_addr_exp);
  endtask

  initial begin
    logic [31:0] ra, wa, saved;
    err_exp      = 1'b0;
    err_addr_exp = 32'h0;
    rst_n         = 1'b0;
    ram_rd_addr_i = 32'h0;
    ram_wr_addr_i = 32'h0;
    ram_wr_data_i = 32'h0;
    ram_wr_en_i   = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rd", ram_rd_data_o, 32'h0);
    check("reset_err", {31'b0, err_o}, 32'h0);
    check("reset_err_addr", err_addr_o, 32'h0);
    rst_n = 1'b1;

    // Fill the random window and the directed addresses with known data.
    for (int i = 0; i < 64; i++) do_cycle(32'h0, 32'(i * 4), $urandom, 4'hF, 1'b0);
    do_cycle(32'h0, 32'h0000_1000, 32'hCAFE_F00D, 4'hF, 1'b0);
    do_cycle(32'h0, 32'h0000_3FFC, 32'h0BAD_CAFE, 4'hF, 1'b0);

    // Random traffic in bytes 0x00..0xFF, low address bits randomized.
    for (int i = 0; i < 400; i++) begin
      ra = 32'({$urandom_range(0, 63), 2'b00}) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) wa = {ra[31:2], 2'($urandom_range(0, 3))};
      else wa = 32'({$urandom_range(0, 63), 2'b00}) | 32'($urandom_range(0, 3));
      do_cycle(ra, wa, $urandom, 4'($urandom_range(0, 15)), 1'b1);
    end

    // Full-word write then read back.
    do_cycle(32'h0, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
    do_cycle(32'h10, 32'h0, 32'h0, 4'h0, 1'b1);
    check("full_word", last_rd, 32'hDEAD_BEEF);

    // Partial lane write.
    do_cycle(32'h0, 32'h20, 32'h1122_3344, 4'hF, 1'b0);
    do_cycle(32'h0, 32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0);
    do_cycle(32'h20, 32'h0, 32'h0, 4'h0, 1'b1);
    check("lane_merge", last_rd, 32'h11BB_33DD);

    // Same-word read/write collision.
    do_cycle(32'h0, 32'h30, 32'h0, 4'hF, 1'b0);
    do_cycle(32'h30, 32'h30, 32'hFFFF_FFFF, 4'b0011, 1'b1);
`ifdef DRAM_FWD_EN
    check("collision", last_rd, 32'h0000_FFFF);
`else
    check("collision", last_rd, 32'h0000_0000);
`endif

    // Last in-range word, then first out-of-range address.
    do_cycle(32'h3FFC, 32'h0, 32'h0, 4'h0, 1'b1);
    check("top_word", last_rd, 32'h0BAD_CAFE);
    do_cycle(32'h4000, 32'h0, 32'h0, 4'h0, 1'b1);
    check("oor_rd_zero", last_rd, 32'h0);
    check("oor_err", {31'b0, err_o}, 32'h1);
    check("oor_err_addr", err_addr_o, 32'h0000_4000);

    // Second out-of-range access: capture held, aliased word untouched.
    do_cycle(32'h0, 32'h5000, 32'h1234_5678, 4'hF, 1'b0);
    check("err_addr_held", err_addr_o, 32'h0000_4000);
    do_cycle(32'h1000, 32'h0, 32'h0, 4'h0, 1'b1);
    check("alias_intact", last_rd, 32'hCAFE_F00D);

    // Reset asserted mid-cycle while a write to 0x40 is presented.
    saved = model[widx(32'h40)];
    ram_rd_addr_i = 32'h40;
    ram_wr_addr_i = 32'h40;
    ram_wr_data_i = ~saved;
    ram_wr_en_i   = 4'hF;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rd_zero", ram_rd_data_o, 32'h0);
    check("async_err_zero", {31'b0, err_o}, 32'h0);
    check("async_err_addr_zero", err_addr_o, 32'h0);
    @(posedge clk);
    #1;
    check("held_rd_zero", ram_rd_data_o, 32'h0);
    ram_wr_en_i  = 4'h0;
    rst_n        = 1'b1;
    err_exp      = 1'b0;
    err_addr_exp = 32'h0;
    do_cycle(32'h40, 32'h0, 32'h0, 4'h0, 1'b1);
    check("reset_write_dropped", last_rd, saved);

    // Simultaneous out-of-range read and write: write address wins.
    do_cycle(32'h4, 32'hFFFF_FFFC, 32'h0, 4'hF, 1'b1);
    check("write_preferred", err_addr_o, 32'hFFFF_FFFC);
    do_cycle(32'h8000_0000, 32'h0, 32'h0, 4'h0, 1'b1);
    check("sticky_addr", err_addr_o, 32'hFFFF_FFFC);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
